// File: rtl/ps_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps_pkg
// Description : Shared constants and helpers for the run-of-four detector.
// Revision    : 1.0 - initial release
// ============================================================================
package ps_pkg;

    localparam int PS_SW = 4;

    // S1..S4 track a run of 1s, S5..S8 a run of 0s; S4/S8 mean "four or more".
    localparam logic [PS_SW-1:0] S0 = 4'd0;
    localparam logic [PS_SW-1:0] S1 = 4'd1;
    localparam logic [PS_SW-1:0] S2 = 4'd2;
    localparam logic [PS_SW-1:0] S3 = 4'd3;
    localparam logic [PS_SW-1:0] S4 = 4'd4;
    localparam logic [PS_SW-1:0] S5 = 4'd5;
    localparam logic [PS_SW-1:0] S6 = 4'd6;
    localparam logic [PS_SW-1:0] S7 = 4'd7;
    localparam logic [PS_SW-1:0] S8 = 4'd8;

    function automatic logic ps_is_match(input logic [PS_SW-1:0] state);
        return (state == S4) || (state == S8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps_step.sv
`default_nettype none
// ============================================================================
// Module      : ps_step
// Description : Single combinational step of the run-of-four pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_step
    import ps_pkg::*;
(
    input  logic [PS_SW-1:0] cur,
    input  logic             in,
    output logic [PS_SW-1:0] nxt,
    output logic             hit
);

    always_comb begin
        nxt = S0;
        case (cur)
            S0, S1, S2, S3: nxt = in ? (cur + 4'd1) : S5;
            S4:             nxt = in ? S4 : S5;
            S5, S6, S7:     nxt = in ? S1 : (cur + 4'd1);
            S8:             nxt = in ? S1 : S8;
            default:        nxt = S0;
        endcase
        hit = ps_is_match(nxt);
    end

endmodule
`default_nettype wire

// File: rtl/ps_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps_share_ctrl
// Description : Round-robin sharing of one run-of-four detector step among NCH
//               bit-stream channels, with per-channel state and tagged result.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_share_ctrl
    import ps_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [NCH-1:0] req_valid,
    input  logic [NCH-1:0] req_bit,
    output logic [NCH-1:0] req_ready,
    input  logic [NCH-1:0] chan_clr,
    output logic           det_valid,
    output logic [CW-1:0]  det_chan,
    output logic           det_out,
    output logic [NCH-1:0] busy_map
);

    localparam logic [CW:0]   c_nch  = (CW+1)'(NCH);
    localparam logic [CW-1:0] c_last = CW'(NCH - 1);

    logic [NCH-1:0][PS_SW-1:0] r_state;
    logic [NCH-1:0][PS_SW-1:0] w_state_d;
    logic [NCH-1:0]            w_busy_d;
    logic [CW-1:0]             r_ptr;
    logic [NCH-1:0]            w_elig;
    logic                      w_grant;
    logic [CW-1:0]             w_gidx;
    logic [CW:0]               w_idx;
    logic [PS_SW-1:0]          w_cur;
    logic [PS_SW-1:0]          w_nxt;
    logic                      w_hit;
    logic                      r_det_valid;
    logic [CW-1:0]             r_det_chan;
    logic                      r_det_out;
    logic [NCH-1:0]            r_busy;

    // A clear on a channel blocks its grant in the same cycle: clear wins.
    assign w_elig = req_valid & ~chan_clr & {NCH{en & ~reset}};

    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = {1'b0, r_ptr} + (CW+1)'(k);
            if (w_idx >= c_nch) begin
                w_idx = w_idx - c_nch;
            end
            if (!w_grant && w_elig[w_idx[CW-1:0]]) begin
                w_grant = 1'b1;
                w_gidx  = w_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    assign w_cur = r_state[w_gidx];

    ps_step u_step (
        .cur (w_cur),
        .in  (req_bit[w_gidx]),
        .nxt (w_nxt),
        .hit (w_hit)
    );

    always_comb begin
        w_state_d = r_state;
        for (int i = 0; i < NCH; i++) begin
            if (reset || chan_clr[i]) begin
                w_state_d[i] = S0;
            end else if (w_grant && (w_gidx == CW'(i))) begin
                w_state_d[i] = w_nxt;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_busy
            assign w_busy_d[gi] = (w_state_d[gi] != S0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_state <= w_state_d;
        r_busy  <= w_busy_d;
        if (reset) begin
            r_ptr       <= '0;
            r_det_valid <= 1'b0;
            r_det_chan  <= '0;
            r_det_out   <= 1'b0;
        end else begin
            r_det_valid <= w_grant;
            if (w_grant) begin
                r_ptr      <= (w_gidx == c_last) ? '0 : (w_gidx + 1'b1);
                r_det_chan <= w_gidx;
                r_det_out  <= w_hit;
            end
        end
    end

    assign det_valid = r_det_valid;
    assign det_chan  = r_det_chan;
    assign det_out   = r_det_out;
    assign busy_map  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ps_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps_share_ctrl
// Description : Directed scoreboard bench for ps_share_ctrl with a run-length
//               reference model and a reference round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps_share_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] req_bit;
    logic [NCH-1:0] req_ready;
    logic [NCH-1:0] chan_clr;
    logic           det_valid;
    logic [CW-1:0]  det_chan;
    logic           det_out;
    logic [NCH-1:0] busy_map;

    int checks   = 0;
    int failures = 0;

    logic [CW:0]   sb_q[$];
    int            m_cnt[NCH];
    logic          m_last[NCH];
    int            m_ptr;
    logic [CW-1:0] m_chan;
    logic          m_out;

    ps_share_ctrl #(.NCH(NCH)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .chan_clr  (chan_clr),
        .det_valid (det_valid),
        .det_chan  (det_chan),
        .det_out   (det_out),
        .busy_map  (busy_map)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] model_busy();
        logic [NCH-1:0] b;
        b = '0;
        for (int i = 0; i < NCH; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic do_reset();
        reset = 1'b1; en = 1'b1; req_valid = '1; req_bit = '0; chan_clr = '0;
        #1 check("rst_ready", req_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_det_valid", det_valid, 0);
        check("rst_det_chan", det_chan, 0);
        check("rst_det_out", det_out, 0);
        check("rst_busy", busy_map, 0);
        for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_last[i] = 1'b0; end
        m_ptr = 0; m_chan = '0; m_out = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive, check grant, update model, check registered outputs.
    task automatic cycle(input logic e, input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                         input logic [NCH-1:0] c);
        logic [NCH-1:0] exp_ready;
        logic [CW:0]    ent;
        int             g;
        int             idx;
        en = e; req_valid = v; req_bit = b; chan_clr = c;
        g = -1;
        exp_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (m_ptr + k) % NCH;
            if (g < 0 && v[idx] && !c[idx] && e) g = idx;
        end
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            if (m_cnt[g] == 0 || m_last[g] != b[g]) begin
                m_cnt[g]  = 1;
                m_last[g] = b[g];
            end else if (m_cnt[g] < 4) begin
                m_cnt[g]++;
            end
            sb_q.push_back({CW'(g), (m_cnt[g] == 4)});
            m_ptr = (g + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) if (c[i]) m_cnt[i] = 0;
        #1 check("req_ready", req_ready, exp_ready);
        @(posedge clk); #1;
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            m_chan = ent[CW:1];
            m_out  = ent[0];
            check("det_valid", det_valid, 1);
        end else begin
            check("det_valid_idle", det_valid, 0);
        end
        check("det_chan", det_chan, m_chan);
        check("det_out", det_out, m_out);
        check("busy_map", busy_map, model_busy());
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; req_valid = '0; req_bit = '0; chan_clr = '0;
        do_reset();

        // ch0 alone, five 1s
        for (int n = 0; n < 5; n++) cycle(1'b1, 4'b0001, 4'b0001, 4'b0000);

        // ch1: 0,0,0,0 then 1,1
        for (int n = 0; n < 4; n++) cycle(1'b1, 4'b0010, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0010, 4'b0010, 4'b0000);
        cycle(1'b1, 4'b0010, 4'b0010, 4'b0000);

        // all channels valid, ch2 always 1, others random
        do_reset();
        for (int n = 0; n < 16; n++) begin
            logic [NCH-1:0] rb;
            rb = 4'($urandom_range(0, 15));
            rb[2] = 1'b1;
            cycle(1'b1, 4'b1111, rb, 4'b0000);
        end
        // clear one channel while others keep requesting
        cycle(1'b1, 4'b1111, 4'b0101, 4'b0010);
        cycle(1'b1, 4'b1111, 4'b0101, 4'b0000);

        // ch3 to S3, then clear concurrent with a request, then a 1
        do_reset();
        for (int n = 0; n < 3; n++) cycle(1'b1, 4'b1000, 4'b1000, 4'b0000);
        cycle(1'b1, 4'b1000, 4'b1000, 4'b1000);
        cycle(1'b1, 4'b1000, 4'b1000, 4'b0000);

        // ch0 to S7, reset pulse, then zeros
        do_reset();
        for (int n = 0; n < 3; n++) cycle(1'b1, 4'b0001, 4'b0000, 4'b0000);
        do_reset();
        for (int n = 0; n < 4; n++) cycle(1'b1, 4'b0001, 4'b0000, 4'b0000);

        // en low for 3 cycles, with a clear acting on ch0 meanwhile
        cycle(1'b1, 4'b0110, 4'b0110, 4'b0000);
        cycle(1'b0, 4'b1111, 4'b1111, 4'b0000);
        cycle(1'b0, 4'b1111, 4'b1111, 4'b0001);
        cycle(1'b0, 4'b1111, 4'b1111, 4'b0000);
        for (int n = 0; n < 6; n++) cycle(1'b1, 4'b1111, 4'b1111, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
